enc_rblwe: RTL and testbench
============================

ENC_RBLWE -- requirements
Module: enc_rblwe

Interface
REQ-001 SHALL have parameter N, default 512, polynomial degree (ring Z_q[x]/(x^N+1)).
REQ-002 SHALL have parameter LOG_Q, default 8, coefficient width; q = 2^LOG_Q.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  N*LOG_Q  public polynomial; coefficient i at bits [i*LOG_Q +: LOG_Q].
REQ-006 p  input  N*LOG_Q  public key polynomial, same packing as a.
REQ-007 e1, e2, e3  input  N each  binary error/secret polynomials; bit i = coefficient i.
REQ-008 m  input  N  message, bit i = message bit i.
REQ-009 start  input  1  request; sampled only in IDLE.
REQ-010 ack  input  1  consumer acknowledge; sampled only in DONE.
REQ-011 c1, c2  output  N*LOG_Q each  ciphertext, packed as a.
REQ-012 valid  output  1  ciphertext valid; busy  output  1  high in MUL and ADD.

Function
REQ-013 SHALL compute c1 = a*e1 + e2 and c2 = p*e1 + e3 + (q/2)*m, negacyclic, all arithmetic mod q by natural LOG_Q-bit wrap.
REQ-014 SHALL implement FSM states IDLE, MUL, ADD, DONE; IDLE->MUL on start; MUL->ADD after N MUL cycles; ADD->DONE unconditionally; DONE->IDLE on ack.
REQ-015 On start accepted at edge T SHALL latch a, p, e1, e2, e3, m and clear both accumulators; later input changes have no effect.
REQ-016 MUL SHALL process one e1 bit per cycle, MSB first (bit N-1 at edge T+1, bit 0 at edge T+N), via a log2(N)-bit counter.
REQ-017 Each MUL step SHALL set acc' = x*acc mod (x^N+1) (acc'[0] = -acc[N-1] mod q, acc'[i] = acc[i-1]) then add a (resp. p) when the current e1 bit is 1.
REQ-018 ADD (edge T+N+1) SHALL add e2[i] to c1 coefficient i and e3[i] + 2^(LOG_Q-1)*m[i] to c2 coefficient i.
REQ-019 valid SHALL be 1 exactly while in DONE, first high in the cycle after edge T+N+1 (latency N+2 cycles from start edge).
REQ-020 c1/c2 SHALL be stable throughout DONE and equal the accumulators.
REQ-021 start outside IDLE SHALL be ignored; ack outside DONE SHALL be ignored.
REQ-022 ack and start together in DONE: return to IDLE, start not accepted; a new start is needed in IDLE.
REQ-023 busy SHALL equal (state==MUL || state==ADD).

Reset
REQ-024 rst SHALL force IDLE, valid=0, busy=0, counter=0, c1=c2=0 at the next edge, overriding any other event, including mid-MUL.
REQ-025 After reset a start SHALL complete with full latency and no residue from the aborted operation.

Configuration
REQ-026 Macro ENC_SECRET_CLEAR_EN: when defined, the DONE->IDLE transition SHALL zero accumulators (c1, c2) and latched e1, e2, e3, m in the same edge.
REQ-027 Without ENC_SECRET_CLEAR_EN, c1/c2 and latched registers SHALL hold their values in IDLE until the next accepted start or reset.

Structure
REQ-028 Package rblwe_pkg SHALL hold default N, LOG_Q, NQ = N*LOG_Q, the FSM state enum, and Q_HALF = 2^(LOG_Q-1).
REQ-029 One sub-module negmul_acc (shift-negate-conditional-add accumulator over N coefficients) SHALL be instantiated twice, for the a and p paths.

Verification
REQ-030 e1 = only bit 0, a all 3, p all 5, e2=e3=m=0 -> c1 all 3, c2 all 5, valid rises 514 cycles after start edge.
REQ-031 e1 = only bit 1, a coefficient 511 = 1 else 0 -> c1 coefficient 0 = 255, others 0 (wrap negation).
REQ-032 e1=0, e3 all ones, m all ones, e2 all ones -> c1 all 1, c2 all 129.
REQ-033 start pulsed at MUL cycle 50 and ack pulsed in MUL -> no effect; valid held through DONE until ack, drops next cycle.
REQ-034 rst at MUL cycle 100 -> IDLE, valid=0, c1=c2=0 next cycle; following start with REQ-030 data gives REQ-030 results.
REQ-035 After ack: with ENC_SECRET_CLEAR_EN c1=c2=0 in IDLE; without, c1/c2 retain REQ-030 values.

Source files
------------

// File: rtl/rblwe_pkg.sv
// Shared defaults and FSM encoding for the ring-binary LWE encryption core.
package rblwe_pkg;

  localparam int N      = 512;
  localparam int LOG_Q  = 8;
  localparam int NQ     = N * LOG_Q;
  localparam int Q_HALF = 1 << (LOG_Q - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/negmul_acc.sv
// Negacyclic accumulator: each step multiplies the polynomial by x mod (x^N+1)
// and optionally adds an operand polynomial; coefficients wrap mod 2^LOG_Q.
module negmul_acc #(
  parameter int N     = rblwe_pkg::N,
  parameter int LOG_Q = rblwe_pkg::LOG_Q
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               add_en,
  input  logic [N*LOG_Q-1:0] addend,
  output logic [N*LOG_Q-1:0] acc
);

  logic [N*LOG_Q-1:0] rotated;
  logic [N*LOG_Q-1:0] next_acc;
  logic [LOG_Q-1:0]   top_coef;
  logic [LOG_Q-1:0]   neg_top;

  // Coefficient N-1 wraps around to position 0 with its sign flipped (x^N = -1).
  always_comb begin
    top_coef = acc[(N-1)*LOG_Q +: LOG_Q];
    neg_top  = ~top_coef + 1'b1;
    rotated  = acc;
    if (shift_en) begin
      rotated = {acc[(N-1)*LOG_Q-1:0], neg_top};
    end
    next_acc = rotated;
    for (int i = 0; i < N; i++) begin
      next_acc[i*LOG_Q +: LOG_Q] = rotated[i*LOG_Q +: LOG_Q] +
                                   (add_en ? addend[i*LOG_Q +: LOG_Q] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (shift_en || add_en) begin
      acc <= next_acc;
    end
  end

endmodule

// File: rtl/enc_rblwe.sv
// RBLWE encryption: c1 = a*e1 + e2, c2 = p*e1 + e3 + (q/2)*m over Z_q[x]/(x^N+1).
// Define ENC_SECRET_CLEAR_EN to wipe results and latched secrets when leaving DONE.
module enc_rblwe #(
  parameter int N     = rblwe_pkg::N,
  parameter int LOG_Q = rblwe_pkg::LOG_Q
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*LOG_Q-1:0] a,
  input  logic [N*LOG_Q-1:0] p,
  input  logic [N-1:0]       e1,
  input  logic [N-1:0]       e2,
  input  logic [N-1:0]       e3,
  input  logic [N-1:0]       m,
  input  logic               start,
  input  logic               ack,
  output logic [N*LOG_Q-1:0] c1,
  output logic [N*LOG_Q-1:0] c2,
  output logic               valid,
  output logic               busy
);
  import rblwe_pkg::*;

  localparam int               CW   = $clog2(N);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [LOG_Q-1:0] HALF = LOG_Q'(1) << (LOG_Q - 1);

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [N*LOG_Q-1:0] a_r, p_r;
  logic [N-1:0]       e1_r, e2_r, e3_r, m_r;
  logic [N*LOG_Q-1:0] add_c1, add_c2, addend1, addend2;
  logic               e1_bit, shift_en, add_en, clear_acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)      next_state = MUL;
      MUL:     if (cnt == LAST) next_state = ADD;
      ADD:                      next_state = DONE;
      DONE:    if (ack)        next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Operands are captured once at start so later input changes cannot disturb the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      a_r  <= '0;
      p_r  <= '0;
      e1_r <= '0;
      e2_r <= '0;
      e3_r <= '0;
      m_r  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt  <= '0;
          a_r  <= a;
          p_r  <= p;
          e1_r <= e1;
          e2_r <= e2;
          e3_r <= e3;
          m_r  <= m;
        end
        MUL: cnt <= cnt + 1'b1;
`ifdef ENC_SECRET_CLEAR_EN
        DONE: if (ack) begin
          e1_r <= '0;
          e2_r <= '0;
          e3_r <= '0;
          m_r  <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Horner evaluation walks e1 from the MSB down; ADD folds in the error and message terms.
  always_comb begin
    add_c1 = '0;
    add_c2 = '0;
    for (int i = 0; i < N; i++) begin
      add_c1[i*LOG_Q +: LOG_Q] = LOG_Q'(e2_r[i]);
      add_c2[i*LOG_Q +: LOG_Q] = LOG_Q'(e3_r[i]) + (m_r[i] ? HALF : '0);
    end
    e1_bit    = e1_r[LAST - cnt];
    shift_en  = (state == MUL);
    add_en    = (state == MUL) ? e1_bit : (state == ADD);
    addend1   = (state == MUL) ? a_r : add_c1;
    addend2   = (state == MUL) ? p_r : add_c2;
    clear_acc = (state == IDLE) && start;
`ifdef ENC_SECRET_CLEAR_EN
    clear_acc = clear_acc || ((state == DONE) && ack);
`endif
  end

  negmul_acc #(.N(N), .LOG_Q(LOG_Q)) u_acc_a (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_acc),
    .shift_en (shift_en),
    .add_en   (add_en),
    .addend   (addend1),
    .acc      (c1)
  );

  negmul_acc #(.N(N), .LOG_Q(LOG_Q)) u_acc_p (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_acc),
    .shift_en (shift_en),
    .add_en   (add_en),
    .addend   (addend2),
    .acc      (c2)
  );

  assign valid = (state == DONE);
  assign busy  = (state == MUL) || (state == ADD);

endmodule

// File: tb/tb_enc_rblwe.sv
// Self-checking bench for enc_rblwe against a direct negacyclic convolution model.
module tb_enc_rblwe;

  localparam int N      = 512;
  localparam int LOG_Q  = 8;
  localparam int NQ     = N * LOG_Q;
  localparam int QMASK  = (1 << LOG_Q) - 1;
  localparam int HALF   = 1 << (LOG_Q - 1);
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NQ-1:0] a = '0, p = '0;
  logic [N-1:0]  e1 = '0, e2 = '0, e3 = '0, m = '0;
  logic          start = 1'b0, ack = 1'b0;
  logic [NQ-1:0] c1, c2;
  logic          valid, busy;

  int            tests = 0;
  int            failures = 0;
  int            m1[N];
  int            m2[N];
  logic [NQ-1:0] exp_c1, exp_c2;

  enc_rblwe #(.N(N), .LOG_Q(LOG_Q)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .p     (p),
    .e1    (e1),
    .e2    (e2),
    .e3    (e3),
    .m     (m),
    .start (start),
    .ack   (ack),
    .c1    (c1),
    .c2    (c2),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reports the first differing coefficient (coefficient 0 when all agree).
  task automatic checkVec(input string tag, input logic [NQ-1:0] obs, input logic [NQ-1:0] exp);
    int idx;
    idx = 0;
    for (int k = N - 1; k >= 0; k--)
      if (obs[k*LOG_Q +: LOG_Q] !== exp[k*LOG_Q +: LOG_Q]) idx = k;
    checkOutput($sformatf("%s[%0d]", tag, idx),
                32'(obs[idx*LOG_Q +: LOG_Q]), 32'(exp[idx*LOG_Q +: LOG_Q]));
  endtask

  // Schoolbook product with x^N = -1, then error and message terms.
  task automatic computeModel();
    for (int k = 0; k < N; k++) begin
      m1[k] = int'(e2[k]);
      m2[k] = int'(e3[k]) + (m[k] ? HALF : 0);
    end
    for (int j = 0; j < N; j++) begin
      if (e1[j]) begin
        for (int i = 0; i < N; i++) begin
          if (i + j < N) begin
            m1[i+j] += int'(a[i*LOG_Q +: LOG_Q]);
            m2[i+j] += int'(p[i*LOG_Q +: LOG_Q]);
          end else begin
            m1[i+j-N] -= int'(a[i*LOG_Q +: LOG_Q]);
            m2[i+j-N] -= int'(p[i*LOG_Q +: LOG_Q]);
          end
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_c1[k*LOG_Q +: LOG_Q] = LOG_Q'(m1[k] & QMASK);
      exp_c2[k*LOG_Q +: LOG_Q] = LOG_Q'(m2[k] & QMASK);
    end
  endtask

  task automatic randomizeInputs();
    for (int i = 0; i < NQ / 32; i++) begin
      a[i*32 +: 32] = $urandom;
      p[i*32 +: 32] = $urandom;
    end
    for (int i = 0; i < N / 32; i++) begin
      e1[i*32 +: 32] = $urandom;
      e2[i*32 +: 32] = $urandom;
      e3[i*32 +: 32] = $urandom;
      m[i*32 +: 32]  = $urandom;
    end
  endtask

  // kind 0: e1=bit0, a=3, p=5; kind 1: e1=bit1, a[N-1]=1; kind 2: e1=0, errors/message all ones; else random.
  task automatic applyStimulus(input int kind);
    a = '0; p = '0; e1 = '0; e2 = '0; e3 = '0; m = '0;
    case (kind)
      0: begin
        e1[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
          a[i*LOG_Q +: LOG_Q] = LOG_Q'(3);
          p[i*LOG_Q +: LOG_Q] = LOG_Q'(5);
        end
      end
      1: begin
        randomizeInputs();
        a = '0; e1 = '0; e2 = '0; e3 = '0; m = '0;
        e1[1] = 1'b1;
        a[(N-1)*LOG_Q +: LOG_Q] = LOG_Q'(1);
      end
      2: begin
        randomizeInputs();
        e1 = '0; e2 = '1; e3 = '1; m = '1;
      end
      default: randomizeInputs();
    endcase
    computeModel();
  endtask

  // Runs one encryption; inputs are scrambled after start to show they were latched.
  task automatic runOp(input bit disturb);
    int lat;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    randomizeInputs();
    while (!valid && lat < BUDGET) begin
      if (lat == 10) checkOutput("busy_in_mul", 32'(busy), 32'd1);
      if (disturb && lat == 50) begin
        start = 1'b1;
        ack   = 1'b1;
      end else begin
        start = 1'b0;
        ack   = 1'b0;
      end
      @(negedge clk); lat++;
    end
    start = 1'b0; ack = 1'b0;
    checkOutput("latency", 32'(lat), 32'(N + 2));
    checkVec("c1", c1, exp_c1);
    checkVec("c2", c2, exp_c2);
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("valid_held", 32'(valid), 32'd1);
    checkVec("c1_held", c1, exp_c1);
    ack = 1'b1;
    start = disturb;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    checkOutput("valid_after_ack", 32'(valid), 32'd0);
    @(negedge clk);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkIdleRetention();
`ifdef ENC_SECRET_CLEAR_EN
    checkVec("c1_idle", c1, '0);
    checkVec("c2_idle", c2, '0);
`else
    checkVec("c1_idle", c1, exp_c1);
    checkVec("c2_idle", c2, exp_c2);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkVec("reset_c1", c1, '0);
    checkVec("reset_c2", c2, '0);

    applyStimulus(0);
    runOp(1'b0);
    checkIdleRetention();

    applyStimulus(1);
    runOp(1'b0);

    applyStimulus(2);
    runOp(1'b0);

    for (int t = 0; t < 3; t++) begin
      applyStimulus(3);
      runOp(t == 1);
    end

    // Abort mid-multiply, then confirm a clean rerun.
    applyStimulus(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkVec("abort_c1", c1, '0);
    checkVec("abort_c2", c2, '0);
    rst = 1'b0;

    applyStimulus(0);
    runOp(1'b0);
    checkIdleRetention();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
